seq_multiplier: RTL and testbench

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/seq_multiplier.sv | 90 +++++++++
 tb/tb_seq_multiplier.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// Sequential shift-and-add unsigned multiplier, one bit per clock.
// Optional macro MULT_ZERO_SKIP_EN: zero operands finish on the accept edge.
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               St,
  input  logic [WIDTH-1:0]   Mcand,
  input  logic [WIDTH-1:0]   Mplier,
  output logic [2*WIDTH-1:0] Product,
  output logic               Busy,
  output logic               Done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mc;
  logic [WIDTH:0]   sum;
  logic             last;
  logic             zero;

  assign last = (cnt == CW'(WIDTH - 1));

`ifdef MULT_ZERO_SKIP_EN
  assign zero = (Mcand == '0) || (Mplier == '0);
`else
  assign zero = 1'b0;
`endif

  // Carry of the add becomes the new MSB once shifted in
  always_comb begin
    sum = {1'b0, Product[2*WIDTH-1:WIDTH]};
    if (Product[0])
      sum = sum + {1'b0, mc};
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (St) state_nx = zero ? DONE : RUN;
      RUN:  if (last) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt     <= '0;
      mc      <= '0;
      Product <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (St) begin
            mc      <= Mcand;
            cnt     <= '0;
            Product <= zero ? '0 : {{WIDTH{1'b0}}, Mplier};
          end
        end
        RUN: begin
          cnt     <= cnt + CW'(1);
          Product <= {sum, Product[WIDTH-1:1]};
        end
        default: ;
      endcase
    end
  end

  assign Busy = (state == RUN);
  assign Done = (state == DONE);

endmodule

// File: tb/tb_seq_multiplier.sv
// Randomized self-checking bench for seq_multiplier (WIDTH 8 and 16).
// Reference model: plain a*b product and fixed-latency rule.
module tb_seq_multiplier;

`ifdef MULT_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        St = 1'b0;
  logic [7:0]  Mcand = '0;
  logic [7:0]  Mplier = '0;
  logic [15:0] Product;
  logic        Busy;
  logic        Done;

  logic        St16 = 1'b0;
  logic [15:0] Mc16 = '0;
  logic [15:0] Mp16 = '0;
  logic [31:0] P16;
  logic        B16;
  logic        D16;

  int n_checks = 0;
  int n_fail = 0;

  always #5 Clk = ~Clk;

  seq_multiplier #(.WIDTH(8)) dut (
    .Clk(Clk), .Reset(Reset), .St(St), .Mcand(Mcand), .Mplier(Mplier),
    .Product(Product), .Busy(Busy), .Done(Done)
  );

  seq_multiplier #(.WIDTH(16)) dut16 (
    .Clk(Clk), .Reset(Reset), .St(St16), .Mcand(Mc16), .Mplier(Mp16),
    .Product(P16), .Busy(B16), .Done(D16)
  );

  // Edges from accept until Done is seen, per the reference rule
  function automatic int exp_lat(input int a, input int b, input int w);
    if (SKIP && (a == 0 || b == 0)) return 0;
    return w;
  endfunction

  // Starts one operation, scrambles operands after accept, waits for Done
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        output int edges, output int busy_n,
                        output logic [15:0] prod);
    @(negedge Clk);
    St = 1'b1; Mcand = a; Mplier = b;
    @(posedge Clk); #1;
    St = 1'b0;
    Mcand = 8'($urandom); Mplier = 8'($urandom);
    edges = 0; busy_n = 0;
    while (!Done && edges < 40) begin
      if (Busy) busy_n++;
      @(posedge Clk); #1;
      edges++;
    end
    prod = Product;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (Product !== 16'd0 || Busy !== 1'b0 || Done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset8: P=%0d B=%b D=%b want 0 0 0", Product, Busy, Done);
    end
    n_checks++;
    if (P16 !== 32'd0 || B16 !== 1'b0 || D16 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset16: P=%0d B=%b D=%b want 0 0 0", P16, B16, D16);
    end
    @(negedge Clk); Reset = 1'b0;
    repeat (2) @(negedge Clk);
    n_checks++;
    if (Product !== 16'd0 || Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_hold: P=%0d B=%b want 0 0", Product, Busy);
    end
  endtask

  task automatic test_op(input string nm, input logic [7:0] a,
                         input logic [7:0] b);
    int e, bn, le;
    logic [15:0] p;
    logic [15:0] want;
    want = 16'(a) * 16'(b);
    le = exp_lat(a, b, 8);
    run_op(a, b, e, bn, p);
    n_checks++;
    if (p !== want || e !== le || bn !== le) begin
      n_fail++;
      $display("FAIL %s: %0d*%0d P=%0d lat=%0d busy=%0d want P=%0d lat=%0d busy=%0d",
               nm, a, b, p, e, bn, want, le, le);
    end
    @(posedge Clk); #1;
    n_checks++;
    if (Done !== 1'b0 || Busy !== 1'b0 || Product !== want) begin
      n_fail++;
      $display("FAIL %s_after: D=%b B=%b P=%0d want 0 0 %0d",
               nm, Done, Busy, Product, want);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      b = 8'($urandom);
      if (i == 3) a = 8'd0;
      if (i == 7) b = 8'd0;
      test_op("random", a, b);
      repeat ($urandom_range(0, 2)) @(posedge Clk);
    end
  endtask

  task automatic test_back_to_back();
    int e;
    @(negedge Clk);
    St = 1'b1; Mcand = 8'd3; Mplier = 8'd5;
    @(posedge Clk); #1;
    Mcand = 8'd7; Mplier = 8'd9;
    e = 0;
    while (!Done && e < 40) begin
      @(posedge Clk); #1; e++;
    end
    n_checks++;
    if (Product !== 16'd15 || e !== 8) begin
      n_fail++;
      $display("FAIL b2b_first: P=%0d lat=%0d want 15 8", Product, e);
    end
    @(posedge Clk); #1;
    n_checks++;
    if (Done !== 1'b0 || Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_gap: D=%b B=%b want 0 0", Done, Busy);
    end
    @(posedge Clk); #1;
    n_checks++;
    if (Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept: B=%b want 1", Busy);
    end
    St = 1'b0;
    e = 0;
    while (!Done && e < 40) begin
      @(posedge Clk); #1; e++;
    end
    n_checks++;
    if (Product !== 16'd63 || e !== 8) begin
      n_fail++;
      $display("FAIL b2b_second: P=%0d lat=%0d want 63 8", Product, e);
    end
    @(posedge Clk);
  endtask

  task automatic test_reset_abort();
    int dn;
    @(negedge Clk);
    St = 1'b1; Mcand = 8'd100; Mplier = 8'd100;
    @(posedge Clk); #1;
    St = 1'b0;
    repeat (4) @(posedge Clk);
    #3;
    Reset = 1'b1;
    #1;
    n_checks++;
    if (Product !== 16'd0 || Busy !== 1'b0 || Done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_async: P=%0d B=%b D=%b want 0 0 0", Product, Busy, Done);
    end
    @(negedge Clk); Reset = 1'b0;
    dn = 0;
    repeat (12) begin
      @(posedge Clk); #1;
      if (Done || Busy) dn++;
    end
    n_checks++;
    if (dn !== 0) begin
      n_fail++;
      $display("FAIL abort_no_done: active cycles=%0d want 0", dn);
    end
    test_op("after_abort", 8'd2, 8'd3);
  endtask

  task automatic test_wide();
    logic [15:0] a [3];
    logic [15:0] b [3];
    a = '{16'd65535, 16'd65535, 16'($urandom)};
    b = '{16'd2, 16'd65535, 16'($urandom | 1)};
    for (int i = 0; i < 3; i++) begin
      int e, le;
      logic [31:0] want;
      want = 32'(a[i]) * 32'(b[i]);
      le = exp_lat(a[i], b[i], 16);
      @(negedge Clk);
      St16 = 1'b1; Mc16 = a[i]; Mp16 = b[i];
      @(posedge Clk); #1;
      St16 = 1'b0; Mc16 = 16'($urandom); Mp16 = 16'($urandom);
      e = 0;
      while (!D16 && e < 60) begin
        @(posedge Clk); #1; e++;
      end
      n_checks++;
      if (P16 !== want || e !== le) begin
        n_fail++;
        $display("FAIL wide: %0d*%0d P=%0d lat=%0d want %0d %0d",
                 a[i], b[i], P16, e, want, le);
      end
      @(posedge Clk);
    end
  endtask

  initial begin
    test_reset();
    test_op("basic_13x11", 8'd13, 8'd11);
    test_op("carry_255x255", 8'd255, 8'd255);
    test_op("zero_0x200", 8'd0, 8'd200);
    test_op("one_1x1", 8'd1, 8'd1);
    test_random();
    test_back_to_back();
    test_reset_abort();
    test_wide();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
